// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - AES-128 round scheduler: four context slots, round-robin issue and output
module aes_round_scheduler #(
  parameter int LAST_ROUND = 10,
  parameter int KEY_W      = 1408
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [127:0]     blk_in_data,
  input  logic             blk_in_vld,
  output logic             blk_in_rdy,
  input  logic [KEY_W-1:0] key_schedule,
  output logic             rnd_vld,
  output logic [127:0]     rnd_data,
  output logic [1:0]       rnd_pntr,
  output logic [3:0]       rnd_num,
  output logic [127:0]     rnd_key,
  input  logic             ret_vld,
  input  logic [1:0]       ret_pntr,
  input  logic [127:0]     ret_data,
  output logic [127:0]     blk_out_data,
  output logic [1:0]       blk_out_pntr,
  output logic             blk_out_vld,
  input  logic             blk_out_rdy,
  output logic             busy,
  output logic             err_ret
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_READY  = 2'd1;
  localparam logic [1:0] S_FLIGHT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [3:0][1:0]   st_q, st_d;
  logic [3:0][3:0]   rnd_q, rnd_d;
  logic [3:0][127:0] dat_q, dat_d;
  logic [1:0]        iss_ptr_q, out_ptr_q;

  logic         alloc_hit, iss_hit, out_hit, out_take, ret_ok;
  logic [1:0]   alloc_idx, iss_idx, out_idx;
  logic [127:0] key_sel;

  // Slot pickers; descending loops let the lowest offset win.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    iss_hit   = 1'b0;
    iss_idx   = '0;
    out_hit   = 1'b0;
    out_idx   = '0;
    busy      = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        alloc_hit = 1'b1;
        alloc_idx = 2'(i);
      end
      if (st_q[iss_ptr_q + 2'(i)] == S_READY) begin
        iss_hit = 1'b1;
        iss_idx = iss_ptr_q + 2'(i);
      end
      // the slot sitting in the output register must not be loaded twice
      if (st_q[out_ptr_q + 2'(i)] == S_DONE &&
          !(blk_out_vld && blk_out_pntr == out_ptr_q + 2'(i))) begin
        out_hit = 1'b1;
        out_idx = out_ptr_q + 2'(i);
      end
      if (st_q[i] != S_FREE) busy = 1'b1;
    end
    blk_in_rdy = alloc_hit;
    ret_ok     = ret_vld && st_q[ret_pntr] == S_FLIGHT;
    out_take   = out_hit && (!blk_out_vld || blk_out_rdy);
    key_sel    = '0;
    for (int r = 0; r <= LAST_ROUND; r++) begin
      if (rnd_q[iss_idx] == 4'(r)) key_sel = key_schedule[KEY_W-1-128*r -: 128];
    end
  end

  // Each event touches a slot in a different state, so they never collide.
  always_comb begin
    st_d  = st_q;
    rnd_d = rnd_q;
    dat_d = dat_q;
    if (blk_in_vld && alloc_hit) begin
      st_d[alloc_idx]  = S_READY;
      rnd_d[alloc_idx] = '0;
      dat_d[alloc_idx] = blk_in_data;
    end
    if (iss_hit) st_d[iss_idx] = S_FLIGHT;
    if (ret_ok) begin
      dat_d[ret_pntr] = ret_data;
      if (rnd_q[ret_pntr] == 4'(LAST_ROUND)) begin
        st_d[ret_pntr] = S_DONE;
      end else begin
        st_d[ret_pntr]  = S_READY;
        rnd_d[ret_pntr] = rnd_q[ret_pntr] + 4'd1;
      end
    end
    if (blk_out_vld && blk_out_rdy) st_d[blk_out_pntr] = S_FREE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q         <= '0;
      rnd_q        <= '0;
      dat_q        <= '0;
      iss_ptr_q    <= '0;
      out_ptr_q    <= '0;
      rnd_vld      <= 1'b0;
      rnd_data     <= '0;
      rnd_pntr     <= '0;
      rnd_num      <= '0;
      rnd_key      <= '0;
      blk_out_vld  <= 1'b0;
      blk_out_data <= '0;
      blk_out_pntr <= '0;
      err_ret      <= 1'b0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      dat_q   <= dat_d;
      rnd_vld <= iss_hit;
      if (iss_hit) begin
        rnd_data  <= dat_q[iss_idx];
        rnd_pntr  <= iss_idx;
        rnd_num   <= rnd_q[iss_idx];
        rnd_key   <= key_sel;
        iss_ptr_q <= iss_idx + 2'd1;
      end
      if (out_take) begin
        blk_out_vld  <= 1'b1;
        blk_out_data <= dat_q[out_idx];
        blk_out_pntr <= out_idx;
        out_ptr_q    <= out_idx + 2'd1;
      end else if (blk_out_rdy) begin
        blk_out_vld <= 1'b0;
      end
      if (ret_vld && !ret_ok) err_ret <= 1'b1;
    end
  end

endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Round scheduler for the AES-128 encryption core. It holds up to four in-flight 128-bit blocks in context slots indexed by the 2-bit pointer number, and issues one slot per cycle into the round datapath (add_round_keys and the round stages) together with its round number and selected 128-bit round key. It collects each round result back from the datapath and re-issues the slot until round 10 completes. It then presents the ciphertext on a valid/ready output port and frees the slot.

## Interface
- LAST_ROUND, 10: final round number; a slot completes when a result for this round returns.
- KEY_W, 1408: width of the expanded key schedule (11 x 128).
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low; clears all state on the first rising clk edge sampled low
- blk_in_data  input  128  plaintext block
- blk_in_vld  input  1  plaintext valid
- blk_in_rdy  output  1  a FREE slot exists; transfer occurs when vld&&rdy
- key_schedule  input  1408  expanded key; round r key = key_schedule[1407-128*r -: 128]
- rnd_vld  output  1  one-cycle issue strobe to the round datapath (no backpressure)
- rnd_data  output  128  slot state data issued
- rnd_pntr  output  2  slot index issued
- rnd_num  output  4  round number issued, 0..10
- rnd_key  output  128  round key for rnd_num
- ret_vld  input  1  round result returning from the datapath
- ret_pntr  input  2  slot index of the returned result
- ret_data  input  128  returned state
- blk_out_data  output  128  ciphertext
- blk_out_pntr  output  2  slot that produced it
- blk_out_vld  output  1  ciphertext valid; held until accepted
- blk_out_rdy  input  1  downstream accepts
- busy  output  1  any slot not FREE
- err_ret  output  1  sticky; set by ret_vld for a slot not in FLIGHT

## Operation
- Per-slot state: FREE, READY (waiting issue), FLIGHT (issued, awaiting return), DONE (result held). Per-slot round counter is 4 bits and per-slot data is 128 bits.
- Allocation: when blk_in_vld&&blk_in_rdy, the lowest-index FREE slot loads blk_in_data, round:=0, and goes FREE->READY. blk_in_rdy is decoded from registered slot state only.
- Issue: each cycle, if any slot is READY, a round-robin arbiter picks one. Search starts at the slot after the last issued slot, modulo 4. The picked slot goes READY->FLIGHT, and rnd_* register {data, pntr, round, key[round]}. If no slot is READY, rnd_vld=0 and the other rnd_* outputs hold their values.
- Return: on ret_vld, if slot ret_pntr is FLIGHT, it stores ret_data.
  - round==LAST_ROUND: slot goes ->DONE.
  - Otherwise: round+1 and slot goes ->READY.
  - If slot ret_pntr is not FLIGHT: data is ignored, no state change, err_ret:=1.
- Output: when the output register is empty, or is being accepted this cycle, it loads the next DONE slot. That slot is picked by a separate round-robin pointer, and blk_out_vld:=1. blk_out_data and blk_out_pntr are stable while vld&&!rdy. On vld&&rdy the slot goes DONE->FREE. A slot already loaded into the output register is not re-selected.
- Simultaneous events on distinct slots (alloc, issue, return, output free) all take effect in the same cycle. Return and issue cannot hit the same slot in one cycle, because a FLIGHT slot is never READY.
- A freed slot is allocatable from the next cycle.
- Round counter never exceeds LAST_ROUND; no wrap.

## Timing
- Reset values:
  - rnd_vld=0, rnd_data=0, rnd_pntr=0, rnd_num=0, rnd_key=0
  - blk_out_vld=0, blk_out_data=0, blk_out_pntr=0
  - busy=0, err_ret=0
  - blk_in_rdy=1 in the first cycle after reset deasserts
  - all slots FREE; both round-robin pointers at slot 0
- Reset mid-operation discards all slots and in-flight results. A ret_vld arriving in the cycle reset is low is ignored.
- Input accepted at edge T: slot READY after T; earliest rnd_vld is the cycle after T+1.
- Return accepted at edge R with round<10: slot READY after R; re-issue is visible at R+2 at the earliest.
- Return with round 10 at edge R: blk_out_vld is high after R+1 at the earliest, if the output register is free.
- Issue throughput is one slot per cycle. Any datapath latency of 1 or more cycles is tolerated.

## Test plan
- Single block, 1-cycle loopback datapath (ret = rnd delayed 1 cycle, data unchanged) -> rnd_num sequence 0..10 on pntr 0; rnd_key at num r equals key_schedule[1407-128r -:128]; blk_out_vld once, pntr 0; slot freed after handshake.
- Four back-to-back inputs with a 3-cycle loopback -> issues rotate pntr 0,1,2,3,0...; blk_in_rdy=0 with four slots busy; fifth input stalls until the first output handshake.
- Hold blk_out_rdy=0 with two slots DONE -> blk_out_data and blk_out_pntr stable; after rdy=1 the second DONE slot follows on the next cycle.
- ret_vld with ret_pntr=2 while slot 2 is FREE -> err_ret=1 and remains 1; other slots unaffected.
- Same-cycle return on slot 1 (round 10), issue of slot 3, input alloc and output accept of slot 0 -> all four effects in one edge; slot 0 re-allocated next cycle.
- Reset low for one cycle mid-run with three slots FLIGHT -> all outputs return to reset values; later returns raise err_ret; the next input restarts at round 0.
